// File: rtl/fp32_pkg.sv
// Shared binary32 constants, flag positions and the pipeline stage record
// used between the normalize stage and the round/pack stage.
package fp32_pkg;

   localparam int BIAS = 127;
   localparam int EXP_MAX = 2 * BIAS + 1;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   localparam int FLAG_OVF = 2;
   localparam int FLAG_UDF = 1;
   localparam int FLAG_NX  = 0;

   typedef enum logic [1:0] {
      CLS_NORM = 2'd0,
      CLS_ZERO = 2'd1,
      CLS_INF  = 2'd2,
      CLS_NAN  = 2'd3
   } fp_class_e;

   typedef struct packed {
      logic              sign;
      logic signed [9:0] exp;
      logic [22:0]       frac;
      logic              g;
      logic              s;
      fp_class_e         cls;
   } stage_rec_t;

   // Product lies in [1,4); bit 47 selects the one-place normalize shift.
   function automatic stage_rec_t normalize(
      input logic              sign,
      input logic signed [9:0] exp,
      input logic [47:0]       prod,
      input logic              is_zero,
      input logic              is_inf,
      input logic              is_nan
   );
      stage_rec_t r;
      r.sign = sign;
      if (prod[47]) begin
         r.frac = prod[46:24];
         r.g    = prod[23];
         r.s    = |prod[22:0];
         r.exp  = exp + 10'sd1;
      end else begin
         r.frac = prod[45:23];
         r.g    = prod[22];
         r.s    = |prod[21:0];
         r.exp  = exp;
      end
      if (is_nan)       r.cls = CLS_NAN;
      else if (is_inf)  r.cls = CLS_INF;
      else if (is_zero) r.cls = CLS_ZERO;
      else              r.cls = CLS_NORM;
      return r;
   endfunction

endpackage

// File: rtl/fp32_round_pack.sv
// Round-to-nearest-even, range check and binary32 packing of one stage record.
module fp32_round_pack
   import fp32_pkg::*;
(
   input  stage_rec_t  rec,
   output logic [31:0] result,
   output logic [2:0]  flags
);

   localparam logic signed [9:0] EXP_TOP = 10'(EXP_MAX);

   logic              round_up;
   logic [23:0]       frac_sum;
   logic signed [9:0] exp_r;

   always_comb begin
      round_up = rec.g & (rec.s | rec.frac[0]);
      frac_sum = {1'b0, rec.frac} + {23'b0, round_up};
      // A carry out leaves frac_sum[22:0] at zero, so only the exponent moves.
      exp_r    = rec.exp + $signed({9'b0, frac_sum[23]});
      result   = '0;
      flags    = '0;
      unique case (rec.cls)
         CLS_NAN:  result = QNAN;
         CLS_INF:  result = {rec.sign, 8'hFF, 23'h0};
         CLS_ZERO: result = {rec.sign, 31'h0};
         default: begin
            if (exp_r >= EXP_TOP) begin
               result          = {rec.sign, 8'hFF, 23'h0};
               flags[FLAG_OVF] = 1'b1;
               flags[FLAG_NX]  = 1'b1;
            end else if (exp_r <= 10'sd0) begin
               result          = {rec.sign, 31'h0};
               flags[FLAG_UDF] = 1'b1;
               flags[FLAG_NX]  = 1'b1;
            end else begin
               result         = {rec.sign, exp_r[7:0], frac_sum[22:0]};
               flags[FLAG_NX] = rec.g | rec.s;
            end
         end
      endcase
   end

endmodule

// File: rtl/fp_mul_round.sv
// Two-stage normalize / round-pack back end of a binary32 multiplier with
// valid/ready handshakes on both sides.
module fp_mul_round
   import fp32_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sign,
   input  logic [9:0]  in_exp,
   input  logic [47:0] in_prod,
   input  logic        in_zero,
   input  logic        in_inf,
   input  logic        in_nan,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [2:0]  out_flags
);

   logic        s1_v;
   logic        s2_v;
   logic        adv_s2;
   stage_rec_t  s1_rec;
   logic [31:0] rp_result;
   logic [2:0]  rp_flags;

   assign adv_s2    = !s2_v || out_ready;
   assign in_ready  = !s1_v || adv_s2;
   assign out_valid = s2_v;

   fp32_round_pack u_round_pack (
      .rec    (s1_rec),
      .result (rp_result),
      .flags  (rp_flags)
   );

   // Stage-1 payload is qualified by s1_v, so it carries no reset.
   always_ff @(posedge clk) begin
      if (in_ready && in_valid)
         s1_rec <= normalize(in_sign, $signed(in_exp), in_prod, in_zero, in_inf, in_nan);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_v       <= 1'b0;
         s2_v       <= 1'b0;
         out_result <= '0;
         out_flags  <= '0;
      end else begin
         if (in_ready)
            s1_v <= in_valid;
         if (adv_s2) begin
            s2_v <= s1_v;
            if (s1_v) begin
               out_result <= rp_result;
               out_flags  <= rp_flags;
            end
         end
      end
   end

endmodule

// File: tb/tb_fp_mul_round.sv
// Directed and randomized bench for fp_mul_round with an arithmetic reference
// model and an in-order scoreboard of expected {result, flags}.
module tb_fp_mul_round;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [47:0] in_prod;
   logic        in_zero, in_inf, in_nan;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [2:0]  out_flags;

   int tests = 0;
   int fails = 0;
   logic [34:0] exp_q[$];

   fp_mul_round dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sign    (in_sign),
      .in_exp     (in_exp),
      .in_prod    (in_prod),
      .in_zero    (in_zero),
      .in_inf     (in_inf),
      .in_nan     (in_nan),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   always #5 clk = ~clk;

   // Value-level rounding: mantissa = P / 2^sh, remainder compared to half an ulp.
   function automatic logic [34:0] model(input logic s, input int e, input logic [47:0] p,
                                         input logic z, input logic i, input logic n);
      longint unsigned pv, mant, rem, half;
      int sh, ex;
      if (n) return {32'h7FC0_0000, 3'b000};
      if (i) return {s, 8'hFF, 23'h0, 3'b000};
      if (z) return {s, 31'h0, 3'b000};
      pv   = 64'(p);
      sh   = (pv >= (64'd1 << 47)) ? 24 : 23;
      ex   = e + sh - 23;
      mant = pv >> sh;
      rem  = pv % (64'd1 << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin
         mant = mant >> 1;
         ex   = ex + 1;
      end
      if (ex >= 255) return {s, 8'hFF, 23'h0, 3'b101};
      if (ex <= 0)   return {s, 31'h0, 3'b011};
      return {s, 8'(ex), 23'(mant), 2'b00, (rem != 0)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic cycle();
      logic [34:0] e;
      @(negedge clk);
      if (!rst) begin
         if (out_valid && out_ready) begin
            tests++;
            assert (exp_q.size() != 0) else begin
               fails++;
               $error("FAIL unexpected_beat observed=%0h expected=none", out_result);
            end
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_result", 64'(out_result), 64'(e[34:3]));
               chk("sb_flags", 64'(out_flags), 64'(e[2:0]));
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(in_sign, int'($signed(in_exp)), in_prod, in_zero, in_inf, in_nan));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic s, input int e, input logic [47:0] p,
                       input logic z, input logic i, input logic n);
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = 10'(e);
      in_prod  = p;
      in_zero  = z;
      in_inf   = i;
      in_nan   = n;
   endtask

   task automatic drain(input string tag);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         cycle();
      end
      chk(tag, 64'(exp_q.size()), 64'd0);
   endtask

   typedef struct {
      string       tag;
      logic        s;
      int          e;
      logic [47:0] p;
      logic        z, i, n;
      logic [31:0] res;
      logic [2:0]  flg;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [31:0] held;
      logic [47:0] p;
      int e, r;

      vecs[0] = '{"sq1p5",    1'b0, 127, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h4010_0000, 3'b000};
      vecs[1] = '{"tie_even", 1'b0, 127, 48'h4000_0040_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0000, 3'b001};
      vecs[2] = '{"tie_odd",  1'b0, 127, 48'h4000_00C0_0000, 1'b0, 1'b0, 1'b0, 32'h3F80_0002, 3'b001};
      vecs[3] = '{"ovf",      1'b0, 255, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h7F80_0000, 3'b101};
      vecs[4] = '{"udf",      1'b1, 0,   48'h4000_0000_0000, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 3'b011};
      vecs[5] = '{"carry",    1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, 1'b0, 1'b0, 32'h4000_0000, 3'b001};
      vecs[6] = '{"nan_prio", 1'b1, 127, 48'h4000_0000_0000, 1'b0, 1'b1, 1'b1, 32'h7FC0_0000, 3'b000};
      vecs[7] = '{"inf",      1'b1, 300, 48'h4000_0000_0000, 1'b1, 1'b1, 1'b0, 32'hFF80_0000, 3'b000};
      vecs[8] = '{"zero",     1'b1, -50, 48'h4000_0000_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 3'b000};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sign = 1'b0; in_exp = '0; in_prod = '0; in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
      repeat (3) cycle();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(out_result), 64'd0);
      chk("rst_flags", 64'(out_flags), 64'd0);
      rst = 1'b0;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // 1.0 * 1.0 with latency check
      out_ready = 1'b1;
      send(1'b0, 127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
      cycle();
      in_valid = 1'b0;
      chk("lat_cycle1", 64'(out_valid), 64'd0);
      cycle();
      chk("lat_cycle2", 64'(out_valid), 64'd1);
      chk("one_result", 64'(out_result), 64'h3F80_0000);
      chk("one_flags", 64'(out_flags), 64'd0);
      cycle();

      foreach (vecs[k]) begin
         send(vecs[k].s, vecs[k].e, vecs[k].p, vecs[k].z, vecs[k].i, vecs[k].n);
         cycle();
         in_valid = 1'b0;
         cycle();
         chk({vecs[k].tag, "_result"}, 64'(out_result), 64'(vecs[k].res));
         chk({vecs[k].tag, "_flags"}, 64'(out_flags), 64'(vecs[k].flg));
         cycle();
      end
      drain("directed_drain");

      // Backpressure: three back-to-back beats into a stalled consumer
      out_ready = 1'b0;
      send(1'b0, 127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
      cycle();
      send(1'b1, 130, 48'h9000_0000_0000, 1'b0, 1'b0, 1'b0);
      cycle();
      chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
      send(1'b0, 100, 48'h5555_5555_5555, 1'b0, 1'b0, 1'b0);
      chk("bp_head", 64'(out_result), 64'(exp_q[0][34:3]));
      held = out_result;
      for (int k = 0; k < 4; k++) begin
         chk("bp_valid_hold", 64'(out_valid), 64'd1);
         chk("bp_result_hold", 64'(out_result), 64'(held));
         chk("bp_in_ready_low", 64'(in_ready), 64'd0);
         cycle();
      end
      out_ready = 1'b1;
      cycle();
      drain("bp_drain");

      // Reset with two beats in flight
      out_ready = 1'b0;
      send(1'b0, 127, 48'h4000_0000_0000, 1'b0, 1'b0, 1'b0);
      cycle();
      send(1'b0, 128, 48'h6000_0000_0000, 1'b0, 1'b0, 1'b0);
      cycle();
      in_valid = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      exp_q.delete();
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         chk("midrst_no_stale", 64'(out_valid), 64'd0);
         cycle();
      end

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         p[31:0]  = $urandom;
         p[47:32] = 16'($urandom);
         r = $urandom_range(2);
         p[47:46] = (r == 0) ? 2'b01 : ((r == 1) ? 2'b10 : 2'b11);
         if ($urandom_range(3) == 0) begin
            p[22:0] = '0;
            if (!p[47]) p[22] = 1'b1;
         end
         if ($urandom_range(7) == 0) p[46:23] = '1;
         e = int'($urandom_range(540)) - 140;
         r = $urandom_range(19);
         send(1'($urandom), e, p, r == 2, r == 1, r == 0);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         cycle();
      end
      drain("rand_drain");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fp_mul_round.md
FP_MUL_ROUND -- requirements
Module: fp_mul_round

Interface
REQ-001 SHALL have no parameters; the format is fixed to IEEE-754 binary32.
REQ-002 SHALL have these ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
REQ-003 SHALL have these upstream ports, fed by the mantissa/exponent multiplier:
- in_valid  input  1  upstream beat present
- in_ready  output  1  block accepts beat this cycle
- in_sign  input  1  s1^s2
- in_exp  input  10  signed two's-complement biased exponent E1+E2-127
- in_prod  input  48  unsigned {1,M1}*{1,M2}, value in [1,4) with binary point after bit 46
- in_zero / in_inf / in_nan  input  1 each  special-operand class from upstream, at most one set
REQ-004 SHALL have these downstream ports:
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts beat
- out_result  output  32  packed binary32
- out_flags  output  3  {overflow, underflow, inexact}

Function
REQ-005 SHALL be a 2-stage pipeline. S1 normalizes; S2 rounds, range-checks and packs. Latency from accept to out_valid SHALL be 2 cycles when there is no stall.
REQ-006 Transfer SHALL occur on valid&&ready at both ports.
REQ-007 Each stage SHALL advance when its successor is empty or advancing: in_ready = !s1_v || (!s2_v || out_ready). Full throughput is 1 beat/cycle.
REQ-008 While out_valid=1 and out_ready=0, out_result and out_flags SHALL stay stable. No beat SHALL be dropped or duplicated, and order SHALL be preserved.
REQ-009 S1, when in_prod[47]=1: frac=in_prod[46:24], G=in_prod[23], S=|in_prod[22:0], exp=in_exp+1.
REQ-010 S1, when in_prod[47]=0: frac=in_prod[45:23], G=in_prod[22], S=|in_prod[21:0], exp=in_exp.
REQ-011 S2 SHALL round to nearest, ties to even: round up iff G && (S || frac[0]).
REQ-012 If round-up carries out of frac (frac all ones), frac SHALL become 0 and exp SHALL increment.
REQ-013 inexact SHALL equal G||S for finite normal results.
REQ-014 Overflow: post-round exp >= 255 SHALL give {sign,8'hFF,23'h0} with overflow=1 and inexact=1.
REQ-015 Underflow: post-round exp <= 0 SHALL flush to {sign,31'h0} with underflow=1 and inexact=1. Subnormals are not produced.
REQ-016 Specials SHALL bypass rounding, with flags=0:
- in_nan gives 32'h7FC00000
- in_inf gives {sign,8'hFF,23'h0}
- in_zero gives {sign,31'h0}
REQ-017 Priority SHALL be nan > inf > zero > computed.
REQ-018 Exponent arithmetic SHALL be 10-bit signed throughout. Range checks SHALL use the signed value, never the truncated 8 bits.

Reset
REQ-019 On rst=1 at a clk edge, s1_v, s2_v and out_valid SHALL clear to 0, out_result SHALL be 32'h0 and out_flags 3'b0.
REQ-020 in_ready SHALL read 1 in the first cycle after reset deasserts.
REQ-021 Reset mid-operation SHALL discard all in-flight beats. No stale beat SHALL appear after reset.
REQ-022 Datapath registers other than the outputs MAY be left unreset. Valid bits SHALL be reset.

Structure
REQ-023 A shared package fp32_pkg SHALL hold:
- BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000
- the flag bit indices
- a typedef for the {sign,exp[9:0],frac[22:0],G,S,class} stage record
REQ-024 Rounding and packing SHALL live in one combinational sub-module, fp32_round_pack, instantiated in S2. Pipeline control SHALL remain in fp_mul_round.

Verification
REQ-025 1.0*1.0: in_exp=127, in_prod=48'h4000_0000_0000, out_ready=1 -> out_result=32'h3F800000, flags=0, out_valid exactly 2 cycles after accept.
REQ-026 1.5*1.5: in_exp=127, in_prod=48'h9000_0000_0000 -> 32'h40100000, flags=0 (normalize-shift path).
REQ-027 Tie to even: in_exp=127, in_prod=48'h4000_0040_0000 (G=1, S=0, frac[0]=0) -> 32'h3F800000 with inexact=1. Same input with frac[0]=1 (in_prod=48'h4000_00C0_0000) -> 32'h3F800002.
REQ-028 Range: in_exp=255 with in_prod=48'h4000_0000_0000 -> 32'h7F800000 with overflow=1. in_exp=0, sign=1 -> 32'h80000000 with underflow=1.
REQ-029 Backpressure: send 3 back-to-back beats with out_ready=0 for 4 cycles.
- in_ready SHALL drop after 2 accepted
- out_result SHALL hold stable while stalled
- after out_ready rises, all 3 results SHALL emerge in order
REQ-030 Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, and none of the 2 flushed results are ever emitted.
